qdiv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `qdiv` sign-magnitude fixed-point divider among `R` requesters. It accepts one division request at a time, issues `start` to the divider, and watches `done` with a watchdog counter. It returns the quotient to the winning requester together with a status code. Divide-by-zero is resolved locally without occupying the divider. The block sits between the requester ports and the single `qdiv #(Q,N)` instance.

---
 rtl/qdiv_arbiter.sv | 149 ++++++++++++++
 tb/tb_qdiv_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdiv_arbiter.sv
// Round-robin arbiter/sequencer sharing one qdiv divider among R requesters.
// Handles divide-by-zero locally and abandons divider operations after TIMEOUT wait cycles.
module qdiv_arbiter #(
  parameter int Q       = 15,
  parameter int N       = 32,
  parameter int R       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_dividend,
  input  logic [R*N-1:0] req_divisor,
  output logic [R-1:0]   resp_valid,
  output logic [N-1:0]   resp_quotient,
  output logic [1:0]     resp_status,
  output logic [N-1:0]   div_dividend,
  output logic [N-1:0]   div_divisor,
  output logic           div_start,
  input  logic [N-1:0]   div_quotient,
  input  logic           div_done,
  output logic [1:0]     dbg_state
);

  localparam int GW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_DIVZ    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  if (R < 2 || Q >= N) begin : g_bad_cfg
    $error("qdiv_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [GW-1:0]   r_last_grant;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   w_gnt;
  logic [GW-1:0]   w_cand;
  logic            w_any;
  logic [N-1:0]    r_dividend;
  logic [N-1:0]    r_divisor;
  logic [N-1:0]    r_quotient;
  logic [1:0]      r_status;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    w_sel_dividend;
  logic [N-1:0]    w_sel_divisor;
  logic            w_divz;
  logic            w_done_ok;
  logic            w_timeout;

  // Search from last_grant+R down to last_grant+1 so the nearest valid requester wins last.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = r_last_grant;
    w_cand = '0;
    for (int k = R; k >= 1; k--) begin
      w_cand = GW'((int'(r_last_grant) + k) % R);
      if (req_valid[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  assign w_sel_dividend = req_dividend[int'(w_gnt)*N +: N];
  assign w_sel_divisor  = req_divisor[int'(w_gnt)*N +: N];
  assign w_divz         = (w_sel_divisor[N-2:0] == '0);
  // Count 0 is the first WAIT cycle; a done seen there belongs to the previous operation.
  assign w_done_ok      = (r_cnt != '0) && div_done;
  assign w_timeout      = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = w_divz ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done_ok || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GW'(R - 1);
      r_grant      <= '0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quotient   <= '0;
      r_status     <= ST_OK;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant      <= w_gnt;
            r_last_grant <= w_gnt;
            r_dividend   <= w_sel_dividend;
            r_divisor    <= w_sel_divisor;
            if (w_divz) begin
              r_quotient <= {w_sel_dividend[N-1] ^ w_sel_divisor[N-1], {(N-1){1'b1}}};
              r_status   <= ST_DIVZ;
            end
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_done_ok) begin
            r_quotient <= div_quotient;
            r_status   <= ST_OK;
          end else if (w_timeout) begin
            r_quotient <= '0;
            r_status   <= ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake: a request transfers on the rising edge where req_valid[i] and req_ready[i]
  // are both high; req_ready is only raised in IDLE, for the single round-robin winner.
  assign req_ready     = (r_state == S_IDLE && w_any && rst_n) ? (R'(1) << w_gnt) : '0;
  assign resp_valid    = (r_state == S_RESP) ? (R'(1) << r_grant) : '0;
  assign resp_quotient = (r_state == S_RESP) ? r_quotient : '0;
  assign resp_status   = (r_state == S_RESP) ? r_status : ST_OK;
  assign div_start     = (r_state == S_ISSUE);
  assign div_dividend  = r_dividend;
  assign div_divisor   = r_divisor;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_qdiv_arbiter.sv
// Directed bench for qdiv_arbiter: vector table of single operations plus
// hand-written round-robin and reset-mid-operation sequences.
module tb_qdiv_arbiter;

  localparam int Q       = 15;
  localparam int N       = 32;
  localparam int R       = 4;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_dividend;
  logic [R*N-1:0] req_divisor;
  logic [R-1:0]   resp_valid;
  logic [N-1:0]   resp_quotient;
  logic [1:0]     resp_status;
  logic [N-1:0]   div_dividend;
  logic [N-1:0]   div_divisor;
  logic           div_start;
  logic [N-1:0]   div_quotient;
  logic           div_done;
  logic [1:0]     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  qdiv_arbiter #(.Q(Q), .N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .resp_valid    (resp_valid),
    .resp_quotient (resp_quotient),
    .resp_status   (resp_status),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_start     (div_start),
    .div_quotient  (div_quotient),
    .div_done      (div_done)
    ,.dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    int         idx;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int         lat;       // cycle offset after ISSUE at which done is driven
    bit         stale;     // drive a bogus done during ISSUE and first WAIT
    logic [N-1:0] exp_q;
    logic [1:0] exp_st;
    int         exp_resp;  // response cycle, counted from accept edge
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural sign-magnitude divider result.
  function automatic logic [N-1:0] div_model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] num;
    logic [2*N-2:0] mag;
    num = {{N{1'b0}}, a[N-2:0]} << Q;
    mag = num / {{N{1'b0}}, b[N-2:0]};
    return {a[N-1] ^ b[N-1], mag[N-2:0]};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    div_done  = 1'b0;
    div_quotient = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: one operation from request to response, called at a negedge
  task automatic do_op(input int n, input vec_t v);
    logic [R-1:0] oh;
    logic [R-1:0] rv;
    logic [N-1:0] rq;
    logic [1:0]   rs;
    int starts, start_cyc, resp_cyc, ready_bad, exp_starts, exp_start_cyc;
    bit acc;
    oh = R'(1) << v.idx;
    req_valid = oh;
    req_dividend[v.idx*N +: N] = v.a;
    req_divisor[v.idx*N +: N]  = v.b;
    div_done = 1'b0;
    div_quotient = '0;
    acc = 1'b0;
    for (int w = 0; w < 10; w++) begin
      #1;
      if (req_ready != '0) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_ready", n), req_ready, oh);
    if (!acc) begin
      req_valid = '0;
      return;
    end
    starts = 0; start_cyc = -1; resp_cyc = -1; ready_bad = 0;
    rv = '0; rq = '0; rs = '0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      if (v.stale && cyc <= 2) begin
        div_done = 1'b1;
        div_quotient = 32'hDEADBEEF;
      end else if (cyc == v.lat + 1) begin
        div_done = 1'b1;
        div_quotient = div_model(v.a, v.b);
      end else begin
        div_done = 1'b0;
        div_quotient = '0;
      end
      #1;
      if (div_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (req_ready != '0) ready_bad++;
      if (resp_valid != '0) begin
        resp_cyc = cyc;
        rv = resp_valid;
        rq = resp_quotient;
        rs = resp_status;
        break;
      end
    end
    @(negedge clk);
    req_valid = '0;
    div_done = 1'b0;
    div_quotient = '0;
    exp_starts    = (v.exp_st == 2'd1) ? 0 : 1;
    exp_start_cyc = (v.exp_st == 2'd1) ? -1 : 1;
    check($sformatf("v%0d_starts", n), starts, exp_starts);
    check($sformatf("v%0d_start_cyc", n), start_cyc, exp_start_cyc);
    check($sformatf("v%0d_resp_cyc", n), resp_cyc, v.exp_resp);
    check($sformatf("v%0d_resp_valid", n), rv, oh);
    check($sformatf("v%0d_quotient", n), rq, v.exp_q);
    check($sformatf("v%0d_status", n), rs, v.exp_st);
    check($sformatf("v%0d_ready_busy", n), ready_bad, 0);
  endtask

  initial begin
    int grants[5];
    int exp_grants[5];
    int ng;

    vecs[0] = '{0, 32'h80104000, 32'h00012000, 3,    1'b0, 32'h800738E3, 2'd0, 5};
    vecs[1] = '{2, 32'h00010000, 32'h80000000, 3,    1'b0, 32'hFFFFFFFF, 2'd1, 1};
    vecs[2] = '{1, 32'h00010000, 32'h00008000, 2,    1'b0, 32'h00010000, 2'd0, 4};
    vecs[3] = '{3, 32'h00030000, 32'h00010000, 5,    1'b0, 32'h00018000, 2'd0, 7};
    vecs[4] = '{1, 32'h80008000, 32'h80004000, 3,    1'b0, 32'h00010000, 2'd0, 5};
    vecs[5] = '{0, 32'h00004000, 32'h00000000, 3,    1'b0, 32'h7FFFFFFF, 2'd1, 1};
    vecs[6] = '{3, 32'h00008000, 32'h00018000, 64,   1'b0, 32'h00002AAA, 2'd0, 66};
    vecs[7] = '{2, 32'h00008000, 32'h80010000, 1000, 1'b0, 32'h00000000, 2'd2, 66};
    vecs[8] = '{2, 32'h00008000, 32'h80010000, 4,    1'b1, 32'h80004000, 2'd0, 6};
    exp_grants = '{0, 1, 2, 3, 0};

    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    div_done     = 1'b0;
    div_quotient = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_operands", {div_dividend, div_divisor}, 0);
    check("rst_state", dbg_state, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_quotient", {resp_quotient, 30'b0, resp_status}, 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_op(i, vecs[i]);

    // round-robin with all requesters continuously valid (divide-by-zero keeps it short)
    apply_reset();
    for (int i = 0; i < R; i++) begin
      req_dividend[i*N +: N] = 32'h00010000;
      req_divisor[i*N +: N]  = 32'h00000000;
    end
    req_valid = 4'hF;
    grants = '{-1, -1, -1, -1, -1};
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
      #1;
      if (req_ready != '0) begin
        for (int j = 0; j < R; j++) if (req_ready[j]) grants[ng] = j;
        ng++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), grants[i], exp_grants[i]);
    req_valid = '0;
    repeat (2) @(negedge clk);

    // reset in the middle of WAIT
    apply_reset();
    req_valid = 4'b0010;
    req_dividend[1*N +: N] = 32'h00010000;
    req_divisor[1*N +: N]  = 32'h00008000;
    #1;
    check("mw_accept", req_ready, 4'b0010);
    repeat (4) @(negedge clk);
    #1;
    check("mw_in_wait", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("mw_rst_ready", req_ready, 0);
    check("mw_rst_resp", {resp_valid, resp_quotient, resp_status}, 0);
    check("mw_rst_div", {div_start, div_dividend, div_divisor}, 0);
    check("mw_rst_state", dbg_state, 0);
    req_valid = 4'b0101;
    req_dividend[0 +: N] = 32'h00010000;
    req_divisor[0 +: N]  = 32'h00000000;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("mw_no_resp", resp_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mw_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    #1;
    check("mw_divz_resp", resp_valid, 4'b0001);
    check("mw_divz_quotient", resp_quotient, 32'h7FFFFFFF);
    check("mw_divz_status", resp_status, 1);
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
